// File: rtl/ivector_pkg.sv
// ============================================================================
//  Module      : ivector_pkg
//  Description : Shared constants, FSM state type and header field helpers
//                for the IVector request deframer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ivector_pkg;

  // Default number of legal method indices carried in a header
  localparam int NUM_METH       = 10;

  // Header layout: method index in the upper half, payload length below it
  localparam int HDR_WORD_WIDTH = 32;
  localparam int HDR_METH_LSB   = 16;
  localparam int HDR_LEN_WIDTH  = 16;
  localparam int HDR_METH_WIDTH = HDR_WORD_WIDTH - HDR_METH_LSB;

  // Frame parser states
  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  // Method index field of a header word
  function automatic logic [HDR_METH_WIDTH-1:0] hdr_meth(
    input logic [HDR_WORD_WIDTH-1:0] word
  );
    return word[HDR_WORD_WIDTH-1:HDR_METH_LSB];
  endfunction

  // Payload length field of a header word
  function automatic logic [HDR_LEN_WIDTH-1:0] hdr_len(
    input logic [HDR_WORD_WIDTH-1:0] word
  );
    return word[HDR_LEN_WIDTH-1:0];
  endfunction

  // A method index is usable only if it addresses an existing FIFO
  function automatic logic meth_is_valid(
    input logic [HDR_METH_WIDTH-1:0] meth,
    input int                        num_meth
  );
    return int'(meth) < num_meth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ivector_request_deframer_say_hold_buffer.sv
// ============================================================================
//  Module      : say_hold_buffer
//  Description : Single-entry holding register for one say(meth, v) call.
//                Fires when full and downstream is ready; a load in the same
//                cycle as a fire replaces the entry and keeps it full.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module say_hold_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_meth,
  input  logic [WIDTH-1:0] load_v,
  input  logic             rdy,
  output logic             full,
  output logic             fire,
  output logic [WIDTH-1:0] meth,
  output logic [WIDTH-1:0] v
);

  logic             r_full;
  logic [WIDTH-1:0] r_meth;
  logic [WIDTH-1:0] r_v;

  // Entry leaves only when it is present and downstream takes it
  assign fire = r_full && rdy;
  assign full = r_full;
  assign meth = r_meth;
  assign v    = r_v;

  // Occupancy: load wins over fire so fire+load leaves the buffer full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (load) begin
      r_full <= 1'b1;
    end else if (fire) begin
      r_full <= 1'b0;
    end
  end

  // Payload registers hold steady until the next load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meth <= '0;
      r_v    <= '0;
    end else if (load) begin
      r_meth <= load_meth;
      r_v    <= load_v;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ivector_request_deframer.sv
// ============================================================================
//  Module      : ivector_request_deframer
//  Description : Parses a 32-bit framed word stream (header + L payload
//                words) into say(meth, v) calls for the IVector FIFO vector.
//                Frames naming an unknown method are swallowed and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ivector_request_deframer #(
  parameter int NUM_METH   = ivector_pkg::NUM_METH,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_in_enq_ena,
  input  logic [DATA_WIDTH-1:0] i_in_enq_v,
  output logic                  o_in_enq_rdy,
  output logic                  o_out_say_ena,
  output logic [DATA_WIDTH-1:0] o_out_say_meth,
  output logic [DATA_WIDTH-1:0] o_out_say_v,
  input  logic                  i_out_say_rdy,
  output logic                  frame_err,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [DATA_WIDTH-1:0] msg_count
);

  import ivector_pkg::*;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [LEN_WIDTH-1:0]      r_remaining;
  logic [LEN_WIDTH-1:0]      w_remaining_nxt;
  logic [DATA_WIDTH-1:0]     r_cur_meth;
  logic [DATA_WIDTH-1:0]     w_cur_meth_nxt;

  logic                      w_buf_full;
  logic                      w_fire;
  logic                      w_enq_rdy;
  logic                      w_accept;
  logic                      w_load;
  logic                      w_msg_done;
  logic                      w_bad_hdr;
  logic [HDR_METH_WIDTH-1:0] w_hdr_meth;
  logic [HDR_LEN_WIDTH-1:0]  w_hdr_len;
  logic                      w_meth_ok;

  assign w_hdr_meth = hdr_meth(i_in_enq_v);
  assign w_hdr_len  = hdr_len(i_in_enq_v);
  assign w_meth_ok  = meth_is_valid(w_hdr_meth, NUM_METH);

  // Headers and dropped words are always welcome; payload needs buffer room
  always_comb begin
    w_enq_rdy = 1'b1;
    if (r_state == PAYLOAD) begin
      w_enq_rdy = !w_buf_full || w_fire;
    end
  end

  assign o_in_enq_rdy  = w_enq_rdy;
  assign w_accept      = i_in_enq_ena && w_enq_rdy;
  assign o_out_say_ena = w_fire;

  // Frame parser: next state, length countdown, latched method, side effects
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_cur_meth_nxt  = r_cur_meth;
    w_load          = 1'b0;
    w_msg_done      = 1'b0;
    w_bad_hdr       = 1'b0;
    case (r_state)
      HDR: begin
        if (w_accept) begin
          if (!w_meth_ok) begin
            w_bad_hdr = 1'b1;
            if (w_hdr_len != '0) begin
              w_remaining_nxt = LEN_WIDTH'(w_hdr_len);
              w_state_nxt     = DROP;
            end
          end else if (w_hdr_len == '0) begin
            w_msg_done = 1'b1;
          end else begin
            w_cur_meth_nxt  = DATA_WIDTH'(w_hdr_meth);
            w_remaining_nxt = LEN_WIDTH'(w_hdr_len);
            w_state_nxt     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (w_accept) begin
          w_load          = 1'b1;
          w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
          if (r_remaining == LEN_WIDTH'(1)) begin
            w_msg_done  = 1'b1;
            w_state_nxt = HDR;
          end
        end
      end
      DROP: begin
        if (w_accept) begin
          w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
          if (r_remaining == LEN_WIDTH'(1)) begin
            w_state_nxt = HDR;
          end
        end
      end
      default: begin
        w_state_nxt = HDR;
      end
    endcase
  end

  // Parser state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= HDR;
      r_remaining <= '0;
      r_cur_meth  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_cur_meth  <= w_cur_meth_nxt;
    end
  end

  // Bad-header bookkeeping: sticky flag plus saturating count
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_err <= 1'b0;
      err_count <= '0;
    end else if (w_bad_hdr) begin
      frame_err <= 1'b1;
      if (err_count != '1) begin
        err_count <= err_count + ERR_WIDTH'(1);
      end
    end
  end

  // Completed good frames, free-running wrap
  always_ff @(posedge CLK) begin
    if (RST) begin
      msg_count <= '0;
    end else if (w_msg_done) begin
      msg_count <= msg_count + DATA_WIDTH'(1);
    end
  end

  say_hold_buffer #(
    .WIDTH (DATA_WIDTH)
  ) u_say_buf (
    .clk       (CLK),
    .rst       (RST),
    .load      (w_load),
    .load_meth (r_cur_meth),
    .load_v    (i_in_enq_v),
    .rdy       (i_out_say_rdy),
    .full      (w_buf_full),
    .fire      (w_fire),
    .meth      (o_out_say_meth),
    .v         (o_out_say_v)
  );

endmodule

`default_nettype wire

// File: tb/tb_ivector_request_deframer.sv
// ============================================================================
//  Module      : tb_ivector_request_deframer
//  Description : Self-checking bench for ivector_request_deframer. A frame
//                level model predicts the say stream and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ivector_request_deframer;

  localparam int NM = 10;
  localparam int EW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_ena = 1'b0;
  logic [31:0] enq_v = '0;
  logic        enq_rdy;
  logic        say_ena;
  logic [31:0] say_meth;
  logic [31:0] say_v;
  logic        say_rdy = 1'b0;
  logic        frame_err;
  logic [EW-1:0] err_count;
  logic [31:0] msg_count;

  ivector_request_deframer #(
    .NUM_METH   (NM),
    .DATA_WIDTH (32),
    .LEN_WIDTH  (16),
    .ERR_WIDTH  (EW)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .i_in_enq_ena   (enq_ena),
    .i_in_enq_v     (enq_v),
    .o_in_enq_rdy   (enq_rdy),
    .o_out_say_ena  (say_ena),
    .o_out_say_meth (say_meth),
    .o_out_say_v    (say_v),
    .i_out_say_rdy  (say_rdy),
    .frame_err      (frame_err),
    .err_count      (err_count),
    .msg_count      (msg_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] meth;
    logic [31:0] v;
  } say_t;

  // Reference model state
  say_t          exp_q[$];
  logic [31:0]   exp_msg;
  logic [EW-1:0] exp_err;
  logic          exp_ferr;
  int            say_cyc[$];
  int            cyc = 0;
  bit            rdy_rand = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Downstream ready jitter when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) say_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Say monitor: every fired say must be the oldest predicted one
  initial begin
    say_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && say_ena) begin
        say_cyc.push_back(cyc);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_say got meth=%h v=%h required no say", say_meth, say_v);
        end else begin
          e = exp_q.pop_front();
          if (say_meth !== e.meth || say_v !== e.v) begin
            n_fail++;
            $display("FAIL say_data got (%h,%h) required (%h,%h)", say_meth, say_v, e.meth, e.v);
          end
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic do_reset();
    rst     = 1'b1;
    enq_ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    say_cyc.delete();
    exp_msg  = '0;
    exp_err  = '0;
    exp_ferr = 1'b0;
  endtask

  // Present one word and hold it until the deframer takes it
  task automatic send_word(input logic [31:0] w);
    int guard = 0;
    enq_v   = w;
    enq_ena = 1'b0;
    @(negedge clk);
    while (!enq_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL enq_timeout got rdy=%b required rdy=1 within 200 cycles", enq_rdy);
      return;
    end
    enq_ena = 1'b1;
    @(posedge clk);
    #1;
    enq_ena = 1'b0;
  endtask

  // Send a whole frame and update the model from the frame rules
  task automatic send_frame(input logic [15:0] meth, input logic [15:0] len,
                            input logic [31:0] first, input bit randw);
    logic [31:0] w;
    bit ok;
    ok = (int'(meth) < NM);
    send_word({meth, len});
    if (!ok) begin
      exp_ferr = 1'b1;
      if (exp_err != '1) exp_err = exp_err + 1'b1;
    end
    for (int i = 0; i < int'(len); i++) begin
      w = randw ? $urandom : first + 32'(i);
      if (ok) exp_q.push_back('{meth: {16'h0, meth}, v: w});
      send_word(w);
    end
    if (ok) exp_msg = exp_msg + 32'd1;
  endtask

  // Let all predicted says drain, then compare counters against the model
  task automatic drain(input string name);
    int guard = 0;
    rdy_rand = 1'b0;
    say_rdy  = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got %0d says pending required 0", name, exp_q.size());
    end
    n_tests++;
    if (msg_count !== exp_msg) begin
      n_fail++;
      $display("FAIL %s_msg_count got %0d required %0d", name, msg_count, exp_msg);
    end
    n_tests++;
    if (err_count !== exp_err) begin
      n_fail++;
      $display("FAIL %s_err_count got %0d required %0d", name, err_count, exp_err);
    end
    n_tests++;
    if (frame_err !== exp_ferr) begin
      n_fail++;
      $display("FAIL %s_frame_err got %b required %b", name, frame_err, exp_ferr);
    end
    @(posedge clk);
    #1;
  endtask

  // Check the last n says came out on consecutive cycles
  task automatic check_consecutive(input string name, input int n);
    bit good;
    good = (say_cyc.size() == n);
    for (int i = 1; good && i < n; i++) good = (say_cyc[i] - say_cyc[i-1] == 1);
    n_tests++;
    if (!good) begin
      n_fail++;
      $display("FAIL %s_timing got %0d says (non-consecutive or wrong count) required %0d back-to-back",
               name, say_cyc.size(), n);
    end
  endtask

  // Post-reset outputs must all be at their idle values
  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    n_tests++;
    if (say_ena !== 1'b0 || say_meth !== 32'h0 || say_v !== 32'h0) begin
      n_fail++;
      $display("FAIL %s_say_out got ena=%b meth=%h v=%h required 0,0,0", name, say_ena, say_meth, say_v);
    end
    n_tests++;
    if (frame_err !== 1'b0 || err_count !== '0 || msg_count !== 32'h0) begin
      n_fail++;
      $display("FAIL %s_counters got ferr=%b err=%0d msg=%0d required 0,0,0",
               name, frame_err, err_count, msg_count);
    end
    n_tests++;
    if (enq_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_enq_rdy got %b required 1", name, enq_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    say_rdy = 1'b1;
    do_reset();
    check_idle_outputs("reset");
  endtask

  task automatic test_good_frame();
    do_reset();
    say_rdy = 1'b1;
    send_frame(16'd3, 16'd2, 32'hAAAA0001, 1'b0);
    drain("good");
    check_consecutive("good", 2);
  endtask

  task automatic test_bad_method();
    do_reset();
    say_rdy = 1'b1;
    send_frame(16'd10, 16'd2, 32'h1234_0000, 1'b0);
    send_frame(16'd1, 16'd1, 32'h0000_0055, 1'b0);
    drain("badmeth");
    check_consecutive("badmeth", 1);
  endtask

  task automatic test_zero_length();
    do_reset();
    say_rdy = 1'b1;
    send_frame(16'd5, 16'd0, 32'h0, 1'b0);
    send_frame(16'd2, 16'd1, 32'h0000_0007, 1'b0);
    drain("zerolen");
    check_consecutive("zerolen", 1);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    logic [31:0] w [3];
    do_reset();
    rdy_rand = 1'b0;
    say_rdy  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      exp_q.push_back('{meth: 32'd4, v: w[i]});
    end
    send_word(32'h0004_0003);
    send_word(w[0]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (enq_rdy !== 1'b0 || say_ena !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stall got %0d cycles with rdy or say high required 0", bad);
    end
    @(posedge clk);
    #1;
    say_rdy = 1'b1;
    send_word(w[1]);
    send_word(w[2]);
    exp_msg = exp_msg + 32'd1;
    drain("bp");
    check_consecutive("bp", 3);
  endtask

  task automatic test_err_saturation();
    do_reset();
    say_rdy = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(16'(10 + i), 16'd0, 32'h0, 1'b0);
    drain("errsat");
    n_tests++;
    if (err_count !== 2'd3) begin
      n_fail++;
      $display("FAIL errsat_value got %0d required 3", err_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    rdy_rand = 1'b0;
    say_rdy  = 1'b0;
    send_word(32'h0006_0004);
    send_word(32'hDEAD_BEEF);
    rst     = 1'b1;
    say_rdy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    say_cyc.delete();
    exp_msg  = '0;
    exp_err  = '0;
    exp_ferr = 1'b0;
    check_idle_outputs("midrst");
    send_frame(16'd0, 16'd1, 32'h0000_0009, 1'b0);
    drain("midrst");
    check_consecutive("midrst", 1);
  endtask

  task automatic test_random();
    do_reset();
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send_frame(16'($urandom_range(0, 12)), 16'($urandom_range(0, 6)), 32'h0, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    drain("random");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_method();
    test_zero_length();
    test_backpressure();
    test_err_saturation();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
